axi_ar_arbiter: RTL

AXI_AR_ARBITER -- requirements
Module: axi_ar_arbiter

---
 rtl/axi_ar_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axi_ar_arbiter.sv
// Round-robin AR-channel arbiter with per-master outstanding-read tracking.
// A grant is locked from selection until the downstream AR handshake completes.
module axi_ar_arbiter #(
  parameter  int NumMasters     = 2,
  parameter  int MaxOutstanding = 4,
  localparam int GrantWidth     = (NumMasters > 1) ? $clog2(NumMasters) : 1,
  localparam int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                  aclk,
  input  logic                  rst_n,
  input  logic [NumMasters-1:0] req_i,
  input  logic                  ar_hs_i,
  input  logic                  r_done_i,
  input  logic [GrantWidth-1:0] r_done_mst_i,
  output logic [NumMasters-1:0] gnt_o,
  output logic [GrantWidth-1:0] gnt_bin_o,
  output logic                  gnt_valid_o,
  output logic [NumMasters-1:0] stall_o,
  output logic                  err_o
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [NumMasters-1:0] gnt_q, gnt_d;
  logic [GrantWidth-1:0] gnt_bin_q, gnt_bin_d;
  logic [GrantWidth-1:0] ptr_q, ptr_d;
  logic                  err_q, err_d;
  logic [CntWidth-1:0]   cnt_q [NumMasters];
  logic [CntWidth-1:0]   cnt_d [NumMasters];

  logic [NumMasters-1:0] elig;
  logic                  sel_found;
  logic [GrantWidth-1:0] sel_idx;
  logic [GrantWidth-1:0] cand;
  logic                  hs_fire;
  logic                  dec_in_range;
  logic                  inc_m, dec_hit_m, dec_m;

  always_comb begin
    for (int m = 0; m < NumMasters; m++) begin
      stall_o[m] = (cnt_q[m] == CntWidth'(MaxOutstanding));
    end
  end

  // First eligible master at or after ptr, wrapping around.
  always_comb begin
    elig      = req_i & ~stall_o;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NumMasters; i++) begin
      cand = GrantWidth'((int'(ptr_q) + i) % NumMasters);
      if (!sel_found && elig[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_bin_d = gnt_bin_q;
    ptr_d     = ptr_q;
    case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d   = StLocked;
          gnt_d     = NumMasters'(1) << sel_idx;
          gnt_bin_d = sel_idx;
        end
      end
      StLocked: begin
        if (ar_hs_i) begin
          state_d   = StIdle;
          gnt_d     = '0;
          gnt_bin_d = '0;
          ptr_d     = (int'(gnt_bin_q) == NumMasters - 1) ? '0 : gnt_bin_q + GrantWidth'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        gnt_d     = '0;
        gnt_bin_d = '0;
      end
    endcase
  end

  assign hs_fire      = (state_q == StLocked) && ar_hs_i;
  assign dec_in_range = int'(r_done_mst_i) < NumMasters;

  // A completion that would underflow or names a nonexistent master is dropped and flagged.
  always_comb begin
    err_d     = err_q;
    inc_m     = 1'b0;
    dec_hit_m = 1'b0;
    dec_m     = 1'b0;
    if (r_done_i && !dec_in_range) begin
      err_d = 1'b1;
    end
    for (int m = 0; m < NumMasters; m++) begin
      inc_m     = hs_fire && (gnt_bin_q == GrantWidth'(m));
      dec_hit_m = r_done_i && dec_in_range && (r_done_mst_i == GrantWidth'(m));
      if (dec_hit_m && (cnt_q[m] == '0)) begin
        err_d = 1'b1;
      end
      dec_m    = dec_hit_m && (cnt_q[m] != '0);
      cnt_d[m] = cnt_q[m];
      if (inc_m && !dec_m) begin
        cnt_d[m] = cnt_q[m] + CntWidth'(1);
      end else if (dec_m && !inc_m) begin
        cnt_d[m] = cnt_q[m] - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      gnt_bin_q <= '0;
      ptr_q     <= '0;
      err_q     <= 1'b0;
      for (int m = 0; m < NumMasters; m++) begin
        cnt_q[m] <= '0;
      end
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_bin_q <= gnt_bin_d;
      ptr_q     <= ptr_d;
      err_q     <= err_d;
      for (int m = 0; m < NumMasters; m++) begin
        cnt_q[m] <= cnt_d[m];
      end
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_bin_o   = gnt_bin_q;
  assign gnt_valid_o = (state_q == StLocked);
  assign err_o       = err_q;

endmodule
